writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage of the CPU. It is the write-side driver of the register file: it produces we, addr_rd and data_in.
- Accepts retired instructions from the MEM stage over a valid/ready handshake and selects the result (ALU, load, PC+4).
- For loads, waits for the data-memory response, then aligns and sign-extends the data.
- Also exports a forwarding bus and a retired-instruction counter.

Parameters:
- W, 32, data width of the register file and datapath.
- N, 32, number of architectural registers; address width is $clog2(N).

Ports:
- clk  in  1  clock, rising-edge logic; the register file samples the outputs on the following falling edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_rd  in  $clog2(N)  destination register.
- in_wb_en  in  1  instruction writes a register.
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- in_funct3  in  3  load type (LB/LH/LW/LBU/LHU).
- in_alu_result  in  W  ALU result; for loads, the byte address.
- in_pc_plus4  in  W  link value.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  W  raw 32-bit word from data memory.
- we  out  1  register-file write enable.
- addr_rd  out  $clog2(N)  register-file write address.
- data_in  out  W  register-file write data.
- fwd_valid  out  1  forwarding bus holds a valid result.
- fwd_rd  out  $clog2(N)  register being forwarded.
- fwd_data  out  W  forwarded value (equals data_in).
- load_err  out  1  misaligned or illegal load detected; one-cycle pulse.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset values (asynchronous, rst low): state IDLE, we 0, addr_rd 0, data_in 0, fwd_valid 0, fwd_rd 0, fwd_data 0, load_err 0, instret 0. Any pending load is discarded.
- FSM states: IDLE, LOAD_WAIT, COMMIT. All outputs except in_ready are registered on posedge clk.
- in_ready is 1 in IDLE and COMMIT, and 0 in LOAD_WAIT.
- Acceptance: an instruction is accepted when in_valid && in_ready. All in_* fields are captured into an internal holding register.
- Non-load accept, from IDLE or COMMIT: next state COMMIT.
  - we = in_wb_en && (in_rd != 0).
  - addr_rd = in_rd.
  - data_in = ALU result for sel 00, PC+4 for sel 10.
  - Sustained throughput is 1 instruction/cycle; latency from accept to we is 1 cycle.
- sel 11: treated as a non-write. we = 0, still retires.
- Load accept: next state LOAD_WAIT and hold.
  - mem_rvalid in the acceptance cycle is ignored; memory responds at the earliest 1 cycle later.
  - In LOAD_WAIT, on mem_rvalid: go to COMMIT with data_in = aligned load value. Latency is 1 cycle after rvalid.
- Load alignment, offset = in_alu_result[1:0]:
  - LB/LBU: byte mem_rdata[8*offset +: 8], sign- or zero-extended to W.
  - LH/LHU: offset must be 0 or 2; halfword mem_rdata[16*offset[1] +: 16], sign- or zero-extended.
  - LW: offset must be 0.
  - Other funct3 values are illegal.
- Misaligned or illegal load: on rvalid, go to COMMIT with we = 0 and load_err = 1 for that cycle. The instruction still counts as retired.
- COMMIT with no new accept: next state IDLE. we, fwd_valid and load_err drop to 0; addr_rd and data_in hold their last values.
- COMMIT with a new accept: follows the same rules as accepting from IDLE (back-to-back operation).
- Forwarding: fwd_valid = we, fwd_rd = addr_rd, fwd_data = data_in, all in the same cycle.
- Register 0: we is never asserted for rd 0, although the register file also protects register 0.
- instret increments by 1 on every cycle in COMMIT (including we = 0 retires) and wraps modulo 2^32.
- Reset mid-operation: reset asserted in LOAD_WAIT returns the FSM to IDLE. A late mem_rvalid arriving in IDLE is ignored; no write occurs.
- Write timing: outputs change only on posedge. we, addr_rd and data_in are therefore stable across the negedge on which the register file writes, so a same-cycle decode read sees the new value.

Decomposition:
- Shared package cpu_pkg holds:
  - wb_sel_t enum: WB_ALU, WB_LOAD, WB_PC4.
  - funct3 constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - wb_state_t enum: IDLE, LOAD_WAIT, COMMIT.
- Sub-module load_align_unit (combinational): inputs funct3, offset, rdata; outputs aligned value and misaligned flag. It gets its own unit bench.

Test Plan:
- ALU write: accept rd=5, sel 00, alu=0x0000_1234 -> next cycle we=1, addr_rd=5, data_in=0x0000_1234, fwd_valid=1; instret=1 one cycle after that.
- rd=0 write: accept rd=0, sel 00, alu=0xFFFF_FFFF -> COMMIT with we=0, fwd_valid=0; instret increments.
- LB sign-extend: accept LB, addr=0x...03; rvalid two cycles later with rdata=0x8000_0000.
  - in_ready=0 while in LOAD_WAIT.
  - Next cycle after rvalid: we=1, data_in=0xFFFF_FF80.
- LHU vs misaligned LH:
  - LHU at offset 2, rdata=0xBEEF_0000 -> data_in=0x0000_BEEF.
  - LH at offset 1 -> load_err=1, we=0.
- Back-to-back: three ALU instructions with in_valid held high (rd=1,2,3) -> we=1 for three consecutive cycles, addr_rd 1,2,3, in_ready stays 1.
- Reset mid-load: rst low during LOAD_WAIT, then high; then pulse mem_rvalid -> outputs stay at reset values, state IDLE, instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback result selects, load funct3 codes and
// writeback FSM state encoding.
package cpu_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10
   } wb_sel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      LOAD_WAIT = 2'b01,
      COMMIT    = 2'b10
   } wb_state_t;

endpackage

// File: rtl/load_align_unit.sv
// Combinational load data aligner: picks the byte/halfword/word addressed by
// offset out of the raw memory word and sign- or zero-extends it.
module load_align_unit
   import cpu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [2:0]   funct3,
   input  logic [1:0]   offset,
   input  logic [W-1:0] rdata,
   output logic [W-1:0] value,
   output logic         misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata[{offset, 3'b000} +: 8];
   assign half_v = rdata[{offset[1], 4'b0000} +: 16];

   always_comb begin
      value      = '0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  value = {{(W-8){byte_v[7]}}, byte_v};
         F3_LBU: value = {{(W-8){1'b0}}, byte_v};
         F3_LH: begin
            value      = {{(W-16){half_v[15]}}, half_v};
            misaligned = offset[0];
         end
         F3_LHU: begin
            value      = {{(W-16){1'b0}}, half_v};
            misaligned = offset[0];
         end
         F3_LW: begin
            value      = rdata;
            misaligned = (offset != 2'b00);
         end
         // Reserved load encodings are reported through the same error path.
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions from MEM, waits on load data, and drives
// the register-file write port, forwarding bus and retired-instruction counter.
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int W = 32,
   parameter int N = 32,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rd,
   input  logic          in_wb_en,
   input  logic [1:0]    in_wb_sel,
   input  logic [2:0]    in_funct3,
   input  logic [W-1:0]  in_alu_result,
   input  logic [W-1:0]  in_pc_plus4,
   input  logic          mem_rvalid,
   input  logic [W-1:0]  mem_rdata,
   output logic          we,
   output logic [AW-1:0] addr_rd,
   output logic [W-1:0]  data_in,
   output logic          fwd_valid,
   output logic [AW-1:0] fwd_rd,
   output logic [W-1:0]  fwd_data,
   output logic          load_err,
   output logic [31:0]   instret
);

   wb_state_t     state, state_d;
   logic          accept, is_load;
   logic [AW-1:0] h_rd;
   logic          h_wb_en;
   logic [2:0]    h_funct3;
   logic [1:0]    h_offset;
   logic [W-1:0]  ld_value;
   logic          ld_err;
   logic          we_d, err_d;
   logic [AW-1:0] addr_d;
   logic [W-1:0]  data_d;

   assign in_ready = (state != LOAD_WAIT);
   assign accept   = in_valid && in_ready;
   assign is_load  = (in_wb_sel == 2'(WB_LOAD));

   // Only the fields a pending load needs later are held; non-load results
   // are written straight from the inputs in the acceptance cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_rd     <= '0;
         h_wb_en  <= 1'b0;
         h_funct3 <= '0;
         h_offset <= '0;
      end else if (accept) begin
         h_rd     <= in_rd;
         h_wb_en  <= in_wb_en;
         h_funct3 <= in_funct3;
         h_offset <= in_alu_result[1:0];
      end
   end

   load_align_unit #(.W(W)) u_align (
      .funct3     (h_funct3),
      .offset     (h_offset),
      .rdata      (mem_rdata),
      .value      (ld_value),
      .misaligned (ld_err)
   );

   always_comb begin
      state_d = state;
      we_d    = 1'b0;
      err_d   = 1'b0;
      addr_d  = addr_rd;
      data_d  = data_in;
      case (state)
         LOAD_WAIT: begin
            if (mem_rvalid) begin
               state_d = COMMIT;
               we_d    = h_wb_en && (h_rd != '0) && !ld_err;
               err_d   = ld_err;
               addr_d  = h_rd;
               data_d  = ld_value;
            end
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               if (is_load) begin
                  state_d = LOAD_WAIT;
               end else begin
                  state_d = COMMIT;
                  we_d    = in_wb_en && (in_rd != '0) && (in_wb_sel != 2'b11);
                  addr_d  = in_rd;
                  data_d  = (in_wb_sel == 2'(WB_PC4)) ? in_pc_plus4 : in_alu_result;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         we        <= 1'b0;
         addr_rd   <= '0;
         data_in   <= '0;
         fwd_valid <= 1'b0;
         fwd_rd    <= '0;
         fwd_data  <= '0;
         load_err  <= 1'b0;
         instret   <= '0;
      end else begin
         state     <= state_d;
         we        <= we_d;
         addr_rd   <= addr_d;
         data_in   <= data_d;
         fwd_valid <= we_d;
         fwd_rd    <= addr_d;
         fwd_data  <= data_d;
         load_err  <= err_d;
         if (state == COMMIT) instret <= instret + 32'd1;
      end
   end

endmodule
